// File: rtl/csa_share_arb_pkg.sv
// Shared constants and state type for the shared carry-select adder arbiter.
package csa_share_arb_pkg;

  localparam int WIDTH_DEF = 44;
  localparam int NREQ_DEF  = 4;
  localparam int ID_W      = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/csa_44bit.sv
// Carry-select adder: each block precomputes sums for carry-in 0 and 1,
// and the incoming block carry picks one. Global carry-in is 0.
module csa_44bit #(
  parameter int WIDTH = 44,
  parameter int BLK   = 11
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NBLK = (WIDTH + BLK - 1) / BLK;

  logic [NBLK:0] carry;

  assign carry[0] = 1'b0;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    // The last block absorbs any remainder when WIDTH is not a multiple of BLK.
    localparam int LO = g * BLK;
    localparam int BW = (g == NBLK - 1) ? (WIDTH - LO) : BLK;

    logic [BW:0] r0;
    logic [BW:0] r1;

    assign r0 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
    assign r1 = r0 + (BW + 1)'(1);

    assign sum[LO +: BW] = carry[g] ? r1[BW-1:0] : r0[BW-1:0];
    assign carry[g+1]    = carry[g] ? r1[BW]     : r0[BW];
  end

  assign cout = carry[NBLK];

endmodule

// File: rtl/csa_share_arb.sv
// Round-robin arbiter sharing one carry-select adder among NREQ requesters,
// with a single registered response slot that supports same-cycle refill.
module csa_share_arb
  import csa_share_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_add_term1,
  input  logic [NREQ*WIDTH-1:0] i_add_term2,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH-1:0]      o_rsp_sum,
  output logic                  o_rsp_cout,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [15:0]           o_op_count
);

  slot_state_e     state;
  slot_state_e     next_state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] cand;
  logic [NREQ-1:0] grant;
  logic            found;
  logic            slot_free;
  logic            req_xfer;
  logic            rsp_xfer;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign o_rsp_valid = (state == FULL);
  assign slot_free   = (state == EMPTY) || i_rsp_ready;
  assign rsp_xfer    = o_rsp_valid && i_rsp_ready;
  // Grants are suppressed while reset is held so nothing appears to transfer.
  assign o_req_ready = (rst_n && slot_free) ? grant : '0;
  assign req_xfer    = |o_req_ready;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NREQ);
      if (!found && i_req_valid[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
    grant[gnt_id] = found;
  end

  assign op_a = i_add_term1[int'(gnt_id) * WIDTH +: WIDTH];
  assign op_b = i_add_term2[int'(gnt_id) * WIDTH +: WIDTH];

  csa_44bit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (op_a),
    .b    (op_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (req_xfer) next_state = FULL;
      FULL:  if (rsp_xfer && !req_xfer) next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ptr        <= '0;
      o_rsp_sum  <= '0;
      o_rsp_cout <= 1'b0;
      o_rsp_id   <= '0;
      o_op_count <= '0;
    end else begin
      state <= next_state;
      if (req_xfer) begin
        o_rsp_sum  <= add_sum;
        o_rsp_cout <= add_cout;
        o_rsp_id   <= gnt_id;
        ptr        <= ID_W'((int'(gnt_id) + 1) % NREQ);
        o_op_count <= o_op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_csa_share_arb.sv
// Self-checking bench for csa_share_arb: a cycle model checked every negedge
// plus directed literal expectations for the key scenarios.
module tb_csa_share_arb;
  import csa_share_arb_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int N = NREQ_DEF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     i_req_valid;
  logic [N-1:0]     o_req_ready;
  logic [N*W-1:0]   i_add_term1;
  logic [N*W-1:0]   i_add_term2;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [W-1:0]     o_rsp_sum;
  logic             o_rsp_cout;
  logic [ID_W-1:0]  o_rsp_id;
  logic [15:0]      o_op_count;

  int checks = 0;
  int errors = 0;

  bit          m_valid;
  logic [W-1:0] m_sum;
  bit          m_cout;
  int          m_id;
  int          m_ptr;
  int          m_count;

  csa_share_arb #(
    .WIDTH (W),
    .NREQ  (N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_add_term1 (i_add_term1),
    .i_add_term2 (i_add_term2),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_sum   (o_rsp_sum),
    .o_rsp_cout  (o_rsp_cout),
    .o_rsp_id    (o_rsp_id),
    .o_op_count  (o_op_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic rsp_ready);
    i_req_valid = valid;
    i_rsp_ready = rsp_ready;
  endtask

  task automatic set_terms(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    i_add_term1[k*W +: W] = a;
    i_add_term2[k*W +: W] = b;
  endtask

  // Requester k presents 100*(k+1) + 7, so sums are 107, 207, 307, 407.
  task automatic init_terms();
    for (int k = 0; k < N; k++) set_terms(k, W'(100 * (k + 1)), W'(7));
  endtask

  // Cycle model: decides what must be visible now, then what the next edge does.
  always @(negedge clk) begin : compare
    int           exp_k;
    logic [N-1:0] exp_ready;
    logic [W:0]   full;
    bit           ok;
    exp_k     = -1;
    exp_ready = '0;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_count = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_id    = 0;
    end else if (!m_valid || i_rsp_ready) begin
      for (int j = 0; j < N; j++)
        if (exp_k < 0 && i_req_valid[(m_ptr + j) % N]) exp_k = (m_ptr + j) % N;
    end
    if (exp_k >= 0) exp_ready[exp_k] = 1'b1;
    ok = (o_req_ready === exp_ready) && (o_rsp_valid === m_valid) &&
         (o_op_count === 16'(m_count));
    if (m_valid || !rst_n)
      ok = ok && (o_rsp_sum === m_sum) && (o_rsp_cout === m_cout) &&
           (o_rsp_id === ID_W'(m_id));
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL model t=%0t ready %b/%b valid %b/%b count %0d/%0d sum %h/%h cout %b/%b id %0d/%0d (got/expected)",
               $time, o_req_ready, exp_ready, o_rsp_valid, m_valid, o_op_count, m_count,
               o_rsp_sum, m_sum, o_rsp_cout, m_cout, o_rsp_id, m_id);
    end
    if (rst_n) begin
      if (exp_k >= 0) begin
        full    = {1'b0, i_add_term1[exp_k*W +: W]} + {1'b0, i_add_term2[exp_k*W +: W]};
        m_sum   = full[W-1:0];
        m_cout  = full[W];
        m_id    = exp_k;
        m_valid = 1'b1;
        m_ptr   = (exp_k + 1) % N;
        m_count = (m_count + 1) % 65536;
      end else if (m_valid && i_rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  logic [W-1:0] va [5];
  logic [W-1:0] vb [5];
  logic [W-1:0] vs [5];
  logic         vc [5];

  initial begin
    va = '{44'h000_0000_07FF, 44'h000_003F_FFFF, 44'h7FF_FFFF_FFFF, 44'hAAA_AAAA_AAAA, 44'hFFF_FFFF_FFFF};
    vb = '{44'h000_0000_0001, 44'h000_0000_0001, 44'h7FF_FFFF_FFFF, 44'h555_5555_5556, 44'hFFF_FFFF_FFFF};
    vs = '{44'h000_0000_0800, 44'h000_0040_0000, 44'hFFF_FFFF_FFFE, 44'h000_0000_0000, 44'hFFF_FFFF_FFFE};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    init_terms();
    applyStimulus(4'b1111, 1'b1);

    // Reset with every requester asking.
    tick(); tick(); #2;
    checkOutput("reset_ready", 64'(o_req_ready), 64'h0);
    checkOutput("reset_rsp_valid", 64'(o_rsp_valid), 64'h0);
    checkOutput("reset_count", 64'(o_op_count), 64'h0);
    checkOutput("reset_sum", 64'(o_rsp_sum), 64'h0);
    checkOutput("reset_id", 64'(o_rsp_id), 64'h0);
    tick(); rst_n = 1'b1; #2;
    checkOutput("first_grant", 64'(o_req_ready), 64'h1);
    tick(); applyStimulus(4'b0000, 1'b1); #2;
    checkOutput("first_rsp_id", 64'(o_rsp_id), 64'h0);
    checkOutput("first_rsp_sum", 64'(o_rsp_sum), 64'd107);

    // Single op from requester 2 wrapping to zero with carry-out.
    tick(); set_terms(2, 44'hFFF_FFFF_FFFF, 44'h000_0000_0001); applyStimulus(4'b0100, 1'b1); #2;
    checkOutput("single_ready", 64'(o_req_ready), 64'h4);
    tick(); applyStimulus(4'b0000, 1'b1); #2;
    checkOutput("single_valid", 64'(o_rsp_valid), 64'h1);
    checkOutput("single_sum", 64'(o_rsp_sum), 64'h0);
    checkOutput("single_cout", 64'(o_rsp_cout), 64'h1);
    checkOutput("single_id", 64'(o_rsp_id), 64'h2);

    // Carry-propagation vectors across the select-block boundaries.
    for (int i = 0; i < 5; i++) begin
      tick(); set_terms(i % N, va[i], vb[i]); applyStimulus(N'(1 << (i % N)), 1'b1);
      tick(); applyStimulus(4'b0000, 1'b1); #2;
      checkOutput($sformatf("vec%0d_sum", i), 64'(o_rsp_sum), 64'(vs[i]));
      checkOutput($sformatf("vec%0d_cout", i), 64'(o_rsp_cout), 64'(vc[i]));
    end

    // Fairness from a fresh reset.
    tick(); rst_n = 1'b0; init_terms();
    tick(); rst_n = 1'b1; applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #2 checkOutput($sformatf("rr_grant%0d", i), 64'(o_req_ready), 64'(1 << (i % N)));
      tick();
    end
    applyStimulus(4'b0011, 1'b0); #2;
    checkOutput("rr_count", 64'(o_op_count), 64'd8);

    // Backpressure: response must hold and no grant may issue.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #2;
      checkOutput($sformatf("bp_ready%0d", i), 64'(o_req_ready), 64'h0);
      checkOutput($sformatf("bp_sum%0d", i), 64'(o_rsp_sum), 64'd407);
      checkOutput($sformatf("bp_id%0d", i), 64'(o_rsp_id), 64'h3);
    end
    tick(); applyStimulus(4'b0011, 1'b1); #2;
    checkOutput("bp_regrant", 64'(o_req_ready), 64'h1);
    tick(); applyStimulus(4'b0000, 1'b1); #2;
    checkOutput("bp_next_id", 64'(o_rsp_id), 64'h0);
    checkOutput("bp_next_sum", 64'(o_rsp_sum), 64'd107);
    checkOutput("bp_count", 64'(o_op_count), 64'd9);

    // Counter wrap with random operands, then reset while FULL.
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1; applyStimulus(4'b1111, 1'b1);
    for (int n = 0; n < 65535; n++) begin
      for (int k = 0; k < N; k++) set_terms(k, W'({$urandom, $urandom}), W'({$urandom, $urandom}));
      tick();
    end
    #2 checkOutput("count_max", 64'(o_op_count), 64'hFFFF);
    tick(); #2;
    checkOutput("count_wrap", 64'(o_op_count), 64'h0);
    checkOutput("wrap_full", 64'(o_rsp_valid), 64'h1);
    rst_n = 1'b0; #1;
    checkOutput("midreset_valid", 64'(o_rsp_valid), 64'h0);
    checkOutput("midreset_ready", 64'(o_req_ready), 64'h0);
    tick(); tick(); rst_n = 1'b1; applyStimulus(4'b0000, 1'b1);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
